// File: rtl/risc_control_sequencer.sv
//-----------------------------------------------------------------------------
// risc_control_sequencer
//
// Control unit for the single-cycle RISC datapath. Owns the run lifecycle
// (LOAD -> CLR -> RUN -> HALT -> LOAD) and, while running, decodes the fetched
// instruction word into the datapath's per-instruction control strobes with
// zero latency. Keeps the architectural NZCV flag register used by branches.
//
// Optional build macro: CTRL_RETIRE_CNT_EN
//   When defined, adds output retire_cnt[15:0], a saturating count of RUN
//   cycles that executed a legal, non-HLT instruction. Cleared by reset and
//   by the CLR state; holds in HALT and LOAD.
//
// Ports:
//   clk            system clock, rising edge
//   clr_n          synchronous active-low reset
//   start          pulse; leave LOAD and begin execution
//   load_req       pulse; return from HALT to LOAD
//   mem_instr_out  instruction word fetched by the datapath
//   Pre_N/Z/C/V    combinational ALU flags of the current instruction
//   test_normal    1 = load mode, external ports own the memories
//   dp_clr         datapath clear (PC, register file)
//   flag_HLT       1 = PC advances, datapath executes
//   halted         in HALT state
//   illegal_op     sticky undefined-opcode indicator (cleared by reset only)
//   nzcv           latched flags {N,Z,C,V}
//   ADC ... flag_OutR  decoded datapath strobes, all 0 outside RUN
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module risc_control_sequencer #(
    parameter int OPW = 5,
    parameter int IW  = 16
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    input  logic          load_req,
    input  logic [IW-1:0] mem_instr_out,
    input  logic          Pre_C,
    input  logic          Pre_V,
    input  logic          Pre_Z,
    input  logic          Pre_N,
    output logic          test_normal,
    output logic          dp_clr,
    output logic          flag_HLT,
    output logic          ADC,
    output logic          SUB,
    output logic          SBB,
    output logic          JMP,
    output logic          BRANCH,
    output logic          Src_ALU_B,
    output logic          Src_Read_B,
    output logic          flag_label_PC,
    output logic          flag_Rm_PC,
    output logic          flag_Rd_PC,
    output logic          flag_mem_RF,
    output logic          flag_ALU_RF,
    output logic          flag_Rm_RF,
    output logic          flag_PC_RF,
    output logic          LHI,
    output logic          LLI,
    output logic          RF_write_en,
    output logic          data_write_en,
    output logic          flag_OutR,
    output logic          halted,
    output logic          illegal_op,
    output logic [3:0]    nzcv
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0]   retire_cnt
`endif
);

    //-------------------------------------------------------------------------
    // Types and opcode map
    //-------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    typedef struct packed {
        logic adc;
        logic sub;
        logic sbb;
        logic jmp;
        logic branch;
        logic src_alu_b;
        logic src_read_b;
        logic label_pc;
        logic rm_pc;
        logic rd_pc;
        logic mem_rf;
        logic alu_rf;
        logic rm_rf;
        logic pc_rf;
        logic lhi;
        logic lli;
        logic rf_we;
        logic data_we;
        logic out_r;
    } strobes_t;

    localparam logic [OPW-1:0] OP_ALU  = 5'b00000;
    localparam logic [OPW-1:0] OP_LLI  = 5'b00001;
    localparam logic [OPW-1:0] OP_LHI  = 5'b00010;
    localparam logic [OPW-1:0] OP_LDR  = 5'b00011;
    localparam logic [OPW-1:0] OP_STR  = 5'b00101;
    localparam logic [OPW-1:0] OP_ADDI = 5'b00111;
    localparam logic [OPW-1:0] OP_SUBI = 5'b01000;
    localparam logic [OPW-1:0] OP_MOV  = 5'b01001;
    localparam logic [OPW-1:0] OP_JMP  = 5'b10000;
    localparam logic [OPW-1:0] OP_JAL  = 5'b10001;
    localparam logic [OPW-1:0] OP_JR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JRM  = 5'b10011;
    localparam logic [OPW-1:0] OP_OUTR = 5'b11100;
    localparam logic [OPW-1:0] OP_HLT  = 5'b11111;

    //-------------------------------------------------------------------------
    // Instruction fields
    //-------------------------------------------------------------------------
    logic [OPW-1:0] op;
    logic [3:0]     cond;
    logic [1:0]     funct;
    logic           is_branch;
    logic           unused_instr_bits;

    assign op        = mem_instr_out[IW-1 -: OPW];
    assign cond      = mem_instr_out[IW-5 -: 4];
    assign funct     = mem_instr_out[1:0];
    // Branches own a 4-bit major opcode (1100); the next four bits are cond.
    assign is_branch = (mem_instr_out[IW-1 -: 4] == 4'b1100);
    // Immediate / register-index bits are consumed by the datapath only.
    assign unused_instr_bits = ^mem_instr_out[IW-9:2];

    //-------------------------------------------------------------------------
    // Branch condition evaluation against the registered flags
    //-------------------------------------------------------------------------
    function automatic logic branch_taken(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    branch_taken = z;
            4'h1:    branch_taken = !z;
            4'h2:    branch_taken = cy;
            4'h3:    branch_taken = !cy;
            4'h4:    branch_taken = n;
            4'h5:    branch_taken = !n;
            4'h6:    branch_taken = v;
            4'h7:    branch_taken = !v;
            4'h8:    branch_taken = cy && !z;
            4'h9:    branch_taken = !cy || z;
            4'hA:    branch_taken = (n == v);
            4'hB:    branch_taken = (n != v);
            4'hC:    branch_taken = !z && (n == v);
            4'hD:    branch_taken = z || (n != v);
            4'hE:    branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    //-------------------------------------------------------------------------
    // Combinational decode
    //-------------------------------------------------------------------------
    strobes_t dec;
    strobes_t strobes;
    logic     legal;
    logic     is_hlt;
    logic     sets_flags;

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        dec        = '0;
        legal      = 1'b1;
        is_hlt     = 1'b0;
        sets_flags = 1'b0;
        case (op)
            OP_ALU: begin
                dec.alu_rf = 1'b1;
                dec.rf_we  = 1'b1;
                dec.adc    = (funct == 2'b01);
                dec.sub    = (funct == 2'b10);
                dec.sbb    = (funct == 2'b11);
                sets_flags = 1'b1;
            end
            OP_LLI: begin
                dec.lli   = 1'b1;
                dec.rf_we = 1'b1;
            end
            OP_LHI: begin
                dec.lhi        = 1'b1;
                dec.src_read_b = 1'b1;
                dec.rf_we      = 1'b1;
            end
            OP_LDR: begin
                dec.src_alu_b = 1'b1;
                dec.mem_rf    = 1'b1;
                dec.rf_we     = 1'b1;
            end
            OP_STR: begin
                dec.src_alu_b  = 1'b1;
                dec.src_read_b = 1'b1;
                dec.data_we    = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                dec.src_alu_b = 1'b1;
                dec.alu_rf    = 1'b1;
                dec.rf_we     = 1'b1;
                dec.sub       = (op == OP_SUBI);
                sets_flags    = 1'b1;
            end
            OP_MOV: begin
                dec.rm_rf = 1'b1;
                dec.rf_we = 1'b1;
            end
            OP_JMP: begin
                dec.jmp      = 1'b1;
                dec.label_pc = 1'b1;
            end
            OP_JAL: begin
                dec.jmp      = 1'b1;
                dec.label_pc = 1'b1;
                dec.pc_rf    = 1'b1;
                dec.rf_we    = 1'b1;
            end
            OP_JR: begin
                dec.jmp   = 1'b1;
                dec.rd_pc = 1'b1;
            end
            OP_JRM: begin
                dec.jmp   = 1'b1;
                dec.rm_pc = 1'b1;
            end
            OP_OUTR: dec.out_r = 1'b1;
            OP_HLT:  is_hlt    = 1'b1;
            default: begin
                if (is_branch) begin
                    dec.branch = branch_taken(cond, nzcv);
                end else begin
                    legal = 1'b0;
                end
            end
        endcase
    end

    // Strobes are live only while running; every other state is quiescent.
    state_t state;

    assign strobes = (state == S_RUN) ? dec : '0;

    assign ADC           = strobes.adc;
    assign SUB           = strobes.sub;
    assign SBB           = strobes.sbb;
    assign JMP           = strobes.jmp;
    assign BRANCH        = strobes.branch;
    assign Src_ALU_B     = strobes.src_alu_b;
    assign Src_Read_B    = strobes.src_read_b;
    assign flag_label_PC = strobes.label_pc;
    assign flag_Rm_PC    = strobes.rm_pc;
    assign flag_Rd_PC    = strobes.rd_pc;
    assign flag_mem_RF   = strobes.mem_rf;
    assign flag_ALU_RF   = strobes.alu_rf;
    assign flag_Rm_RF    = strobes.rm_rf;
    assign flag_PC_RF    = strobes.pc_rf;
    assign LHI           = strobes.lhi;
    assign LLI           = strobes.lli;
    assign RF_write_en   = strobes.rf_we;
    assign data_write_en = strobes.data_we;
    assign flag_OutR     = strobes.out_r;

    //-------------------------------------------------------------------------
    // Lifecycle FSM with registered mode outputs
    //-------------------------------------------------------------------------
    // Mode outputs {test_normal, dp_clr, flag_HLT, halted} for a given state;
    // loaded alongside the state so they come straight from flops.
    function automatic logic [3:0] mode_outputs(input state_t s);
        case (s)
            S_LOAD:  mode_outputs = 4'b1000;
            S_CLR:   mode_outputs = 4'b0100;
            S_RUN:   mode_outputs = 4'b0010;
            default: mode_outputs = 4'b0001;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!clr_n) begin
            // NOTE: reset is synchronous; it only acts on a rising clk edge.
            state      <= S_LOAD;
            nzcv       <= 4'b0000;
            illegal_op <= 1'b0;
            {test_normal, dp_clr, flag_HLT, halted} <= mode_outputs(S_LOAD);
        end else begin
            case (state)
                S_LOAD: begin
                    if (start) begin
                        state <= S_CLR;
                        {test_normal, dp_clr, flag_HLT, halted} <= mode_outputs(S_CLR);
                    end
                end
                S_CLR: begin
                    // Each run starts with clean flags.
                    state <= S_RUN;
                    nzcv  <= 4'b0000;
                    {test_normal, dp_clr, flag_HLT, halted} <= mode_outputs(S_RUN);
                end
                S_RUN: begin
                    if (sets_flags) begin
                        nzcv <= {Pre_N, Pre_Z, Pre_C, Pre_V};
                    end
                    if (!legal) begin
                        illegal_op <= 1'b1;
                    end
                    if (is_hlt || !legal) begin
                        state <= S_HALT;
                        {test_normal, dp_clr, flag_HLT, halted} <= mode_outputs(S_HALT);
                    end
                end
                default: begin
                    if (load_req) begin
                        state <= S_LOAD;
                        {test_normal, dp_clr, flag_HLT, halted} <= mode_outputs(S_LOAD);
                    end
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // Optional retired-instruction counter
    //-------------------------------------------------------------------------
`ifdef CTRL_RETIRE_CNT_EN
    logic retire_ok;

    assign retire_ok = (state == S_RUN) && legal && !is_hlt;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            retire_cnt <= 16'h0000;
        end else if (state == S_CLR) begin
            retire_cnt <= 16'h0000;
        end else if (retire_ok && (retire_cnt != 16'hFFFF)) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`else
    // Retire counter not built.
`endif

endmodule
